// File: rtl/vga_pkg.sv
// vga_pkg
// Shared definitions for the VGA raster generator: coordinate widths, the
// default 800x600@60 timing constants, and the bundle type that groups the
// display-enable and sync signals so they can be delayed together.
package vga_pkg;

  localparam int unsigned H_COORD_W = 11;
  localparam int unsigned V_COORD_W = 10;

  // 800x600@60 (40 MHz pixel clock) timing.
  localparam int unsigned DEF_H_VISIBLE = 800;
  localparam int unsigned DEF_H_FP      = 40;
  localparam int unsigned DEF_H_SYNC    = 128;
  localparam int unsigned DEF_H_BP      = 88;
  localparam int unsigned DEF_V_VISIBLE = 600;
  localparam int unsigned DEF_V_FP      = 1;
  localparam int unsigned DEF_V_SYNC    = 4;
  localparam int unsigned DEF_V_BP      = 23;

  typedef struct packed {
    logic disp_enbl;
    logic hsync;
    logic vsync;
  } vga_sig_t;

  // Bundle value outside the visible area and outside both sync pulses.
  function automatic vga_sig_t sig_idle(input logic pol);
    vga_sig_t s;
    s.disp_enbl = 1'b0;
    s.hsync     = ~pol;
    s.vsync     = ~pol;
    return s;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// One raster axis: a position counter that wraps at TOTAL-1, plus decode of
// the visible region and the sync window for the position it will hold after
// the current clock edge.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   advance     step the position by one this cycle
//   count       position after this edge (held value when not advancing)
//   wrap        advancing from TOTAL-1 back to 0 this cycle
//   active      count lies in the visible region
//   sync        SYNC_POL while count is inside the sync window, else inverse
module vga_axis_counter #(
  parameter int unsigned VISIBLE  = 800,
  parameter int unsigned FP       = 40,
  parameter int unsigned SYNC     = 128,
  parameter int unsigned BP       = 88,
  parameter bit          SYNC_POL = 1'b1,
  parameter int unsigned W        = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         advance,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         active,
  output logic         sync
);

  localparam int unsigned TOTAL = VISIBLE + FP + SYNC + BP;

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);
  // Window bounds carry one extra bit so a bound equal to 2**W still fits.
  localparam logic [W:0] VIS_END    = (W+1)'(VISIBLE);
  localparam logic [W:0] SYNC_START = (W+1)'(VISIBLE + FP);
  localparam logic [W:0] SYNC_END   = (W+1)'(VISIBLE + FP + SYNC);

  logic [W-1:0] cnt_q;
  logic [W:0]   count_ext;

  always_comb begin
    wrap  = advance && (cnt_q == LAST);
    count = cnt_q;
    if (advance) begin
      count = wrap ? '0 : cnt_q + 1'b1;
    end
    count_ext = {1'b0, count};
    active    = count_ext < VIS_END;
    sync      = ((count_ext >= SYNC_START) && (count_ext < SYNC_END)) ? SYNC_POL : ~SYNC_POL;
  end

  // Resetting to the last position makes the first advance land on 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= LAST;
    end else begin
      cnt_q <= count;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// VGA raster timing: pixel/line coordinates, display enable, hsync/vsync,
// a one-clock frame-start pulse and a free-running 8-bit frame counter.
// Everything advances only on cycles where i_pix_ce is high.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_pix_ce        pixel clock enable, one pixel per asserted cycle
//   o_h_coord       current column
//   o_v_coord       current line
//   o_disp_enbl     coordinate lies in the visible area
//   o_hsync         horizontal sync, SYNC_POL when active
//   o_vsync         vertical sync, SYNC_POL when active
//   o_frame_start   one-clock pulse when the position becomes (0,0)
//   o_frame_cnt     frame index, increments at each frame start
// Build option:
//   VGA_PIPE_DELAY_EN  when defined, enable and syncs lag the coordinates by
//                      PIPE_DELAY pixel ticks to line up with synchronous-ROM
//                      renderers; otherwise PIPE_DELAY has no effect.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter bit          SYNC_POL   = 1'b1,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_pix_ce,
  output logic [H_COORD_W-1:0] o_h_coord,
  output logic [V_COORD_W-1:0] o_v_coord,
  output logic                 o_disp_enbl,
  output logic                 o_hsync,
  output logic                 o_vsync,
  output logic                 o_frame_start,
  output logic [7:0]           o_frame_cnt
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

`ifdef VGA_PIPE_DELAY_EN
  localparam int unsigned DEPTH = PIPE_DELAY;
`else
  localparam int unsigned DEPTH = 0;
`endif

  if (H_TOTAL > 2**H_COORD_W) begin : g_chk_h_total
    $error("H_TOTAL does not fit the horizontal coordinate width");
  end
  if (V_TOTAL > 2**V_COORD_W) begin : g_chk_v_total
    $error("V_TOTAL does not fit the vertical coordinate width");
  end
  if ((H_SYNC == 0) || (H_VISIBLE + H_FP + H_SYNC > H_TOTAL)) begin : g_chk_h_sync
    $error("hsync window must lie inside H_TOTAL");
  end
  if ((V_SYNC == 0) || (V_VISIBLE + V_FP + V_SYNC > V_TOTAL)) begin : g_chk_v_sync
    $error("vsync window must lie inside V_TOTAL");
  end
  if (PIPE_DELAY < 1) begin : g_chk_pipe
    $error("PIPE_DELAY must be at least 1");
  end

  logic [H_COORD_W-1:0] h_next;
  logic [V_COORD_W-1:0] v_next;
  logic                 h_wrap, h_active, h_sync;
  logic                 v_wrap, v_active, v_sync;
  logic                 v_adv;
  logic [7:0]           frame_q;
  vga_sig_t             sig_cur;
  vga_sig_t             sig_pipe [0:DEPTH];

  assign v_adv = i_pix_ce && h_wrap;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FP      (H_FP),
    .SYNC    (H_SYNC),
    .BP      (H_BP),
    .SYNC_POL(SYNC_POL),
    .W       (H_COORD_W)
  ) u_h_axis (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .advance(i_pix_ce),
    .count  (h_next),
    .wrap   (h_wrap),
    .active (h_active),
    .sync   (h_sync)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FP      (V_FP),
    .SYNC    (V_SYNC),
    .BP      (V_BP),
    .SYNC_POL(SYNC_POL),
    .W       (V_COORD_W)
  ) u_v_axis (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .advance(v_adv),
    .count  (v_next),
    .wrap   (v_wrap),
    .active (v_active),
    .sync   (v_sync)
  );

  always_comb begin
    sig_cur.disp_enbl = h_active && v_active;
    sig_cur.hsync     = h_sync;
    sig_cur.vsync     = v_sync;
  end

  // v only wraps while h wraps, so v_wrap marks the step onto (0,0).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_h_coord     <= '0;
      o_v_coord     <= '0;
      o_frame_start <= 1'b0;
      o_frame_cnt   <= '0;
      frame_q       <= '1;
    end else begin
      o_frame_start <= 1'b0;
      if (i_pix_ce) begin
        o_h_coord     <= h_next;
        o_v_coord     <= v_next;
        o_frame_start <= v_wrap;
        if (v_wrap) begin
          frame_q     <= frame_q + 8'd1;
          o_frame_cnt <= frame_q + 8'd1;
        end
      end
    end
  end

  // Stage 0 is the zero-latency output register; extra stages, when
  // present, delay enable/syncs by whole pixel ticks.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH + 1; i++) begin
        sig_pipe[i] <= sig_idle(SYNC_POL);
      end
    end else if (i_pix_ce) begin
      sig_pipe[0] <= sig_cur;
      for (int unsigned i = 1; i < DEPTH + 1; i++) begin
        sig_pipe[i] <= sig_pipe[i-1];
      end
    end
  end

  assign o_disp_enbl = sig_pipe[DEPTH].disp_enbl;
  assign o_hsync     = sig_pipe[DEPTH].hsync;
  assign o_vsync     = sig_pipe[DEPTH].vsync;

endmodule
